// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states and the architectural fetch
// addresses used by the fetch stage and its bench.
package pipeline_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDRESS = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Avalon-style instruction memory port: read/waitrequest request side with
// zero-latency readdata.
interface fetch_stage_if;

  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, output read, input waitrequest, input readdata);
  modport slave  (input address, input read, output waitrequest, output readdata);

endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over the imem port, holds a
// word across downstream stalls, applies redirects and halts on a jump to zero.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = pipeline_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDRESS = pipeline_pkg::HALT_ADDRESS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_fetch,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_target,
  fetch_stage_if.master        imem,
  output logic [INSTR_W-1:0]   instruction_fetch,
  output logic [31:0]          program_counter_plus_four_fetch,
  output logic                 instruction_valid_fetch,
  output logic                 active
);

  fetch_state_t        r_state;
  logic [31:0]         r_pc;
  logic [INSTR_W-1:0]  r_hold_instr;
  logic [31:0]         r_hold_pc4;
  logic                r_pending;
  logic [31:0]         r_pending_pc;

  logic                w_read;
  logic                w_done;
  logic [31:0]         w_pc_plus4;
  logic [31:0]         w_jump_pc;
  fetch_state_t        w_jump_state;

  // Read is gated by reset so an asserted reset abandons a transfer at once.
  assign w_read     = (r_state == FETCH) && !reset;
  assign w_done     = w_read && !imem.waitrequest;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign imem.address = r_pc;
  assign imem.read    = w_read;
  assign active       = (r_state != HALTED);

  // A same-cycle redirect overrides one captured earlier during a wait.
  assign w_jump_pc    = redirect_valid ? redirect_target : r_pending_pc;
  assign w_jump_state = (w_jump_pc == HALT_ADDRESS) ? HALTED : FETCH;

  always_comb begin
    instruction_fetch               = '0;
    program_counter_plus_four_fetch = '0;
    instruction_valid_fetch         = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          instruction_fetch               = imem.readdata;
          program_counter_plus_four_fetch = w_pc_plus4;
          instruction_valid_fetch         = w_done && !r_pending && !redirect_valid && !stall_fetch;
        end
        HOLD: begin
          instruction_fetch               = r_hold_instr;
          program_counter_plus_four_fetch = r_hold_pc4;
          instruction_valid_fetch         = !stall_fetch && !redirect_valid;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_VECTOR;
      r_hold_instr <= '0;
      r_hold_pc4   <= '0;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_done) begin
            r_pending <= 1'b0;
            if (redirect_valid || r_pending) begin
              r_pc    <= w_jump_pc;
              r_state <= w_jump_state;
            end else begin
              r_pc <= w_pc_plus4;
              if (stall_fetch) begin
                r_hold_instr <= imem.readdata;
                r_hold_pc4   <= w_pc_plus4;
                r_state      <= HOLD;
              end
            end
          end else if (redirect_valid) begin
            // Address must stay put mid-transfer; remember where to go next.
            r_pending    <= 1'b1;
            r_pending_pc <= redirect_target;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_pc    <= redirect_target;
            r_state <= w_jump_state;
          end else if (!stall_fetch) begin
            r_state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences and
// a randomized run against a transaction-level fetch model.
module tb_fetch_stage;
  import pipeline_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall_fetch;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction_fetch;
  logic [31:0] program_counter_plus_four_fetch;
  logic        instruction_valid_fetch;
  logic        active;

  logic        drv_wreq;
  logic [31:0] drv_rdata;
  logic        tbl_mode;

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.waitrequest = drv_wreq;
  assign bus.readdata    = tbl_mode ? drv_rdata : mem_word(bus.address);

  fetch_stage dut (
    .clk                             (clk),
    .reset                           (reset),
    .stall_fetch                     (stall_fetch),
    .redirect_valid                  (redirect_valid),
    .redirect_target                 (redirect_target),
    .imem                            (bus),
    .instruction_fetch               (instruction_fetch),
    .program_counter_plus_four_fetch (program_counter_plus_four_fetch),
    .instruction_valid_fetch         (instruction_valid_fetch),
    .active                          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          redir;
    logic [31:0] tgt;
    bit          wreq;
    logic [31:0] rdata;
    bit          e_read;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    bit          e_active;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input bit rst, input bit stall, input bit redir,
                              input logic [31:0] tgt, input bit wreq,
                              input logic [31:0] rdata, input bit e_read,
                              input logic [31:0] e_addr, input bit e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input bit e_active);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.tgt = tgt; v.wreq = wreq;
    v.rdata = rdata; v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_active = e_active;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit e_read, input logic [31:0] e_addr,
                         input bit e_valid, input logic [31:0] e_instr,
                         input logic [31:0] e_pc4, input bit e_active);
    chk({tag, ".read"},   {31'd0, bus.read}, {31'd0, e_read});
    chk({tag, ".active"}, {31'd0, active},   {31'd0, e_active});
    if (e_read) chk({tag, ".addr"}, bus.address, e_addr);
    chk({tag, ".valid"}, {31'd0, instruction_valid_fetch}, {31'd0, e_valid});
    if (e_valid) begin
      chk({tag, ".instr"}, instruction_fetch, e_instr);
      chk({tag, ".pc4"},   program_counter_plus_four_fetch, e_pc4);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall_fetch = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; drv_wreq = 1'b1;
    @(negedge clk);
    #1;
    chk("rst.read",   {31'd0, bus.read}, 32'd0);
    chk("rst.valid",  {31'd0, instruction_valid_fetch}, 32'd0);
    chk("rst.instr",  instruction_fetch, 32'd0);
    chk("rst.pc4",    program_counter_plus_four_fetch, 32'd0);
    chk("rst.active", {31'd0, active}, 32'd1);
    reset = 1'b0;
  endtask

  task automatic drive(input bit stall, input bit redir, input logic [31:0] tgt,
                       input bit wreq, input logic [31:0] rdata);
    @(negedge clk);
    stall_fetch = stall; redirect_valid = redir; redirect_target = tgt;
    drv_wreq = wreq; drv_rdata = rdata;
    #1;
  endtask

  // Transaction-level model: either halted, holding one word, or fetching at
  // m_pc with at most one redirect remembered from an unfinished transfer.
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_held;
  logic [31:0] m_hi, m_hp4;
  logic [31:0] m_q[$];

  task automatic m_reset();
    m_pc = RESET_VECTOR; m_halted = 0; m_held = 0; m_q.delete();
  endtask

  task automatic m_goto(input logic [31:0] t);
    m_pc = t;
    m_q.delete();
    if (t == HALT_ADDRESS) m_halted = 1;
  endtask

  task automatic m_step(input string tag, input bit stall, input bit redir,
                        input logic [31:0] tgt, input bit wreq);
    bit got;
    got = !wreq;
    if (m_halted) begin
      chk_out(tag, 0, 32'd0, 0, 32'd0, 32'd0, 0);
    end else if (m_held) begin
      chk_out(tag, 0, 32'd0, !stall && !redir, m_hi, m_hp4, 1);
      if (redir) begin m_held = 0; m_goto(tgt); end
      else if (!stall) m_held = 0;
    end else begin
      chk_out(tag, 1, m_pc, got && m_q.size() == 0 && !redir && !stall,
              mem_word(m_pc), m_pc + 32'd4, 1);
      if (!got) begin
        if (redir) begin m_q.delete(); m_q.push_back(tgt); end
      end else if (redir) m_goto(tgt);
      else if (m_q.size() != 0) m_goto(m_q[0]);
      else begin
        if (stall) begin m_held = 1; m_hi = mem_word(m_pc); m_hp4 = m_pc + 32'd4; end
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall_fetch = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    drv_wreq = 1'b1; drv_rdata = '0; tbl_mode = 1'b1;

    //            rst st rd tgt            wr rdata          rd addr           v  instr          pc4            act
    tbl[0]  = mk(1, 0, 0, 32'h0,          0, 32'h0000_0011, 1, 32'hBFC0_0000, 1, 32'h0000_0011, 32'hBFC0_0004, 1);
    tbl[1]  = mk(0, 0, 0, 32'h0,          0, 32'h0000_0022, 1, 32'hBFC0_0004, 1, 32'h0000_0022, 32'hBFC0_0008, 1);
    tbl[2]  = mk(0, 0, 0, 32'h0,          0, 32'h0000_0033, 1, 32'hBFC0_0008, 1, 32'h0000_0033, 32'hBFC0_000C, 1);
    tbl[3]  = mk(1, 0, 0, 32'h0,          1, 32'hDEAD_0001, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0,         1);
    tbl[4]  = mk(0, 1, 0, 32'h0,          1, 32'hDEAD_0002, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0,         1);
    tbl[5]  = mk(0, 0, 0, 32'h0,          1, 32'hDEAD_0003, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0,         1);
    tbl[6]  = mk(0, 0, 0, 32'h0,          0, 32'h2402_0005, 1, 32'hBFC0_0000, 1, 32'h2402_0005, 32'hBFC0_0004, 1);
    tbl[7]  = mk(0, 0, 0, 32'h0,          0, 32'h0000_0044, 1, 32'hBFC0_0004, 1, 32'h0000_0044, 32'hBFC0_0008, 1);
    tbl[8]  = mk(1, 1, 0, 32'h0,          0, 32'h8C43_0000, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0,         1);
    tbl[9]  = mk(0, 1, 0, 32'h0,          0, 32'h1111_1111, 0, 32'h0,         0, 32'h0,         32'h0,         1);
    tbl[10] = mk(0, 0, 0, 32'h0,          0, 32'h2222_2222, 0, 32'h0,         1, 32'h8C43_0000, 32'hBFC0_0004, 1);
    tbl[11] = mk(0, 0, 0, 32'h0,          0, 32'h0000_0055, 1, 32'hBFC0_0004, 1, 32'h0000_0055, 32'hBFC0_0008, 1);
    tbl[12] = mk(1, 0, 1, 32'hBFC0_0100,  1, 32'h0,         1, 32'hBFC0_0000, 0, 32'h0,         32'h0,         1);
    tbl[13] = mk(0, 0, 0, 32'h0,          0, 32'h0BAD_0BAD, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0,         1);
    tbl[14] = mk(0, 0, 0, 32'h0,          0, 32'h0000_0066, 1, 32'hBFC0_0100, 1, 32'h0000_0066, 32'hBFC0_0104, 1);
    tbl[15] = mk(0, 1, 0, 32'h0,          0, 32'h0000_0077, 1, 32'hBFC0_0104, 0, 32'h0,         32'h0,         1);
    tbl[16] = mk(0, 0, 1, 32'hBFC0_0100,  0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         1);
    tbl[17] = mk(0, 0, 0, 32'h0,          0, 32'h0000_0088, 1, 32'hBFC0_0100, 1, 32'h0000_0088, 32'hBFC0_0104, 1);
    tbl[18] = mk(0, 0, 1, 32'hBFC0_0200,  0, 32'h0BAD_0001, 1, 32'hBFC0_0104, 0, 32'h0,         32'h0,         1);
    tbl[19] = mk(0, 0, 0, 32'h0,          0, 32'h0000_0099, 1, 32'hBFC0_0200, 1, 32'h0000_0099, 32'hBFC0_0204, 1);
    tbl[20] = mk(0, 0, 1, 32'hBFC0_0300,  1, 32'h0,         1, 32'hBFC0_0204, 0, 32'h0,         32'h0,         1);
    tbl[21] = mk(0, 0, 1, 32'hBFC0_0400,  1, 32'h0,         1, 32'hBFC0_0204, 0, 32'h0,         32'h0,         1);
    tbl[22] = mk(0, 0, 0, 32'h0,          0, 32'h0BAD_0002, 1, 32'hBFC0_0204, 0, 32'h0,         32'h0,         1);
    tbl[23] = mk(0, 0, 0, 32'h0,          0, 32'h0000_00AA, 1, 32'hBFC0_0400, 1, 32'h0000_00AA, 32'hBFC0_0404, 1);

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].stall, tbl[i].redir, tbl[i].tgt, tbl[i].wreq, tbl[i].rdata);
      chk_out($sformatf("vec%0d", i), tbl[i].e_read, tbl[i].e_addr, tbl[i].e_valid,
              tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_active);
    end

    // Jump to the halt address stops fetching for good.
    do_reset();
    drive(0, 1, HALT_ADDRESS, 0, 32'h0BAD_0003);
    chk_out("halt.jump", 1, RESET_VECTOR, 0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 32'h0, 0, 32'h1234_5678);
      chk_out($sformatf("halt%0d", i), 0, 32'h0, 0, 32'h0, 32'h0, 0);
    end

    // Reset landing in the middle of a wait drops the read immediately.
    do_reset();
    drive(0, 0, 32'h0, 1, 32'h0);
    chk_out("rmid.wait", 1, RESET_VECTOR, 0, 32'h0, 32'h0, 1);
    #2 reset = 1'b1;
    #1;
    chk("rmid.read",  {31'd0, bus.read}, 32'd0);
    chk("rmid.valid", {31'd0, instruction_valid_fetch}, 32'd0);
    chk("rmid.pc4",   program_counter_plus_four_fetch, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0000_00BB);
    chk_out("rmid.restart", 1, RESET_VECTOR, 1, 32'h0000_00BB, 32'hBFC0_0004, 1);

    // Sequential wrap to address 0 is not a halt.
    do_reset();
    drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0BAD_0004);
    chk_out("wrap.jump", 1, RESET_VECTOR, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 32'h0, 0, 32'h0000_00CC);
    chk_out("wrap.top", 1, 32'hFFFF_FFFC, 1, 32'h0000_00CC, 32'h0000_0000, 1);
    drive(0, 0, 32'h0, 0, 32'h0000_00DD);
    chk_out("wrap.zero", 1, 32'h0000_0000, 1, 32'h0000_00DD, 32'h0000_0004, 1);

    // Randomized run against the model.
    tbl_mode = 1'b0;
    do_reset();
    m_reset();
    begin
      int halted_cycles;
      halted_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
        bit s, r, w;
        logic [31:0] t;
        if (m_halted) halted_cycles++;
        if (halted_cycles > 3) begin
          do_reset();
          m_reset();
          halted_cycles = 0;
        end
        s = ($urandom_range(0, 9) < 3);
        w = ($urandom_range(0, 9) < 4);
        r = ($urandom_range(0, 14) == 0);
        case ($urandom_range(0, 59))
          0:       t = HALT_ADDRESS;
          1:       t = 32'hFFFF_FFFC;
          default: t = {16'hBFC0, 14'($urandom), 2'b00};
        endcase
        drive(s, r, t, w, 32'h0);
        m_step($sformatf("rnd%0d", i), s, r, t, w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
